ip_rx_parser: RTL and testbench
===============================

# ip_rx_parser

Receive-side IPv4 header parser, clocked in the MAC receive domain. It takes the byte stream of an IPv4 packet from the MAC layer (Ethernet header already removed) and validates the IP header. Packets that pass are forwarded as payload bytes on the `rx_axis_ip_*` stream, with `tdest` selecting UDP or ICMP for the downstream protocol handlers. Packets that fail are dropped whole.

## Interface
- `BCAST_EN`, default 1: when 1, destination 255.255.255.255 is accepted in addition to `local_ip`.
- `rx_mac_aclk`  in  1: clock.
- `rx_mac_reset`  in  1: reset, asynchronous, active-high.
- `local_ip`  in  32: station IPv4 address. Quasi-static; sampled at header byte 19.
- `rx_axis_mac_tdata`  in  8: IPv4 packet byte (byte 0 = version/IHL).
- `rx_axis_mac_tvalid`  in  1: byte valid. No backpressure; gaps are allowed.
- `rx_axis_mac_tlast`  in  1: last byte of the frame, which may include Ethernet padding.
- `rx_axis_mac_tuser`  in  1: MAC error (FCS or PHY). Meaningful only with `tlast`.
- `rx_axis_ip_tdata`  out  8: payload byte.
- `rx_axis_ip_tvalid`  out  1: payload byte valid. No `tready`.
- `rx_axis_ip_tlast`  out  1: last payload byte.
- `rx_axis_ip_tuser`  out  2: qualified by `tlast`. [0] = MAC error, [1] = IP error (truncated packet). 0 on other beats.
- `rx_axis_ip_tdest`  out  1: 0 = UDP (protocol 17), 1 = ICMP (protocol 1). Constant within a packet.
- `rx_ip_src_addr`  out  32: source IP of the packet currently being forwarded.
- `rx_ip_drop`  out  1: one-cycle pulse for each rejected packet.

## Operation
- States:
  - SYNC (entered on reset): discard bytes until the first input `tlast`, then go to IDLE.
  - IDLE
  - HDR
  - PAYLOAD
  - PAD
  - DROP
- IDLE → HDR on the first valid byte. The byte counter (11 bits) is 0 at byte 0 and increments on each `tvalid`.
- HDR captures the following fields:
  - version and IHL (byte 0)
  - total length (bytes 2–3)
  - flags and fragment offset (bytes 6–7)
  - protocol (byte 9)
  - source IP (bytes 12–15)
  - destination IP (bytes 16–19)
- Header checksum:
  - One's-complement sum of the 16-bit big-endian words over bytes 0 to 4·IHL−1, checksum field included.
  - The accumulator is 20 bits wide.
  - At the end of the header, fold twice: `s = s[15:0] + s[19:16]`, then fold again.
  - The header is good only if the folded result equals 0xFFFF.
- Options (IHL > 5) are covered by the checksum and are not forwarded.
- At the last header byte, reject the packet if any of these hold:
  - version ≠ 4
  - IHL < 5
  - checksum bad
  - destination ≠ `local_ip` and not (BCAST_EN and destination = 0xFFFFFFFF)
  - protocol ∉ {1, 17}
  - MF = 1 or fragment offset ≠ 0
  - total length ≤ 4·IHL
- On reject: pulse `rx_ip_drop`. Go to IDLE if that byte carried input `tlast`, otherwise go to DROP.
- DROP: discard bytes until input `tlast`, then go to IDLE.
- Input `tlast` during HDR: packet is dropped, `rx_ip_drop` pulses, go to IDLE.
- On accept: latch `rx_ip_src_addr` and `tdest`, set the payload count to total length − 4·IHL, and go to PAYLOAD.
- PAYLOAD, per input byte:
  - Forward the byte.
  - If it is the last byte by count and input `tlast` is on the same byte: emit it with output `tlast`, `tuser = {0, rx_axis_mac_tuser}`, and go to IDLE.
  - If it is the last byte by count without input `tlast`: hold the byte and go to PAD.
  - If input `tlast` arrives before the count is reached: emit that byte with output `tlast`, `tuser = {1, rx_axis_mac_tuser}`, and go to IDLE.
- PAD: discard padding bytes. On input `tlast`, emit the held byte with output `tlast`, `tuser = {0, rx_axis_mac_tuser}`, and go to IDLE.

## Timing
- Reset values:
  - all outputs 0
  - `rx_ip_src_addr` = 0
  - state SYNC
- Reset asserted mid-packet:
  - Outputs drop to 0 immediately (asynchronous).
  - No `tlast` is generated for the interrupted packet.
  - The remainder of that packet is discarded via SYNC.
  - SYNC also discards the first frame after power-up, because the block cannot tell whether it woke mid-frame.
- Latency:
  - A payload byte accepted at cycle N appears on the output at N+1.
  - A held byte (PAD) appears at T+1, where T is the cycle carrying input `tlast`.
- The first payload byte may arrive the cycle directly after the last header byte. The accept/reject decision is therefore registered at the last header byte.
- Input gaps (`tvalid` = 0) propagate as output gaps. The output never has two consecutive `tvalid` cycles unless the input did.
- `rx_ip_drop` asserts 1 cycle after the deciding byte.
- `rx_ip_src_addr` is stable from the first output beat of a packet through its `tlast`.
- A new packet may begin the cycle after input `tlast`. IDLE accepts byte 0 without any bubble.

## Test plan
- **Valid ICMP echo**: 20-byte header, total length 60, destination = `local_ip` = 192.168.1.10, correct checksum, no padding → 40 bytes out, `tdest` = 1, `tlast` on byte 40, `tuser` = 00, each byte at N+1.
- **UDP with padding**: total length 28 inside a 46-byte frame, frame `tuser` = 1 → 8 bytes out, `tdest` = 0. The 8th byte is output only at T+1 after the frame `tlast`, with `tuser` = 01.
- **Rejects, one packet each**:
  - bad checksum (word flipped by 0x0001)
  - destination 192.168.1.11
  - protocol 6
  - MF set
  - version 6
  
  → no output beats, exactly one `rx_ip_drop` pulse per packet, and the next valid packet is forwarded intact.
- **Truncation**: total length 100, frame ends after 50 bytes → 30 bytes out, `tlast` on byte 30, `tuser[1]` = 1.
- **IHL = 6 with a 4-byte option** and a correct checksum → payload starts at byte 24. The option bytes are not forwarded.
- **Reset mid-payload**, then a continuing tail of the old frame, then a valid packet → outputs 0 during reset, tail discarded, valid packet forwarded; back-to-back packets with no gap between them are both forwarded.

Source files
------------

// File: rtl/ip_rx_parser.sv
// Receive-side IPv4 header parser. It validates each header from the MAC byte stream,
// forwards accepted payload bytes tagged UDP/ICMP, and drops rejected packets whole.
module ip_rx_parser #(
    parameter bit BCAST_EN = 1'b1
) (
    input  logic        rx_mac_aclk,
    input  logic        rx_mac_reset,
    input  logic [31:0] local_ip,
    input  logic [7:0]  rx_axis_mac_tdata,
    input  logic        rx_axis_mac_tvalid,
    input  logic        rx_axis_mac_tlast,
    input  logic        rx_axis_mac_tuser,
    output logic [7:0]  rx_axis_ip_tdata,
    output logic        rx_axis_ip_tvalid,
    output logic        rx_axis_ip_tlast,
    output logic [1:0]  rx_axis_ip_tuser,
    output logic        rx_axis_ip_tdest,
    output logic [31:0] rx_ip_src_addr,
    output logic        rx_ip_drop
);

    localparam logic [7:0] PROTO_ICMP = 8'd1;
    localparam logic [7:0] PROTO_UDP  = 8'd17;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        HDR,
        PAYLOAD,
        PAD,
        DROP
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]  ver_q, ver_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [15:0] tot_len_q, tot_len_d;
    logic        frag_bad_q, frag_bad_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [23:0] dst_hi_q, dst_hi_d;
    logic        dst_ok_q, dst_ok_d;
    logic [7:0]  csum_hi_q, csum_hi_d;
    logic [19:0] csum_q, csum_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [7:0]  hold_q, hold_d;

    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [1:0]  out_user_q, out_user_d;
    logic        out_dest_q, out_dest_d;
    logic [31:0] src_addr_q, src_addr_d;
    logic        drop_q, drop_d;

    // Header decision terms, evaluated against the byte currently on the input.
    logic        beat;
    logic [10:0] hdr_end;
    logic [15:0] hdr_len;
    logic [31:0] dst_now;
    logic        dst_now_match;
    logic        dst_pass;
    logic [19:0] csum_sum;
    logic [19:0] csum_fold1;
    logic [15:0] csum_fold2;
    logic        csum_ok;
    logic        proto_ok;
    logic        reject;

    assign beat     = rx_axis_mac_tvalid;
    assign hdr_end  = (ihl_q < 4'd5) ? 11'd19 : ({5'd0, ihl_q, 2'b00} - 11'd1);
    assign hdr_len  = {10'd0, ihl_q, 2'b00};
    assign dst_now  = {dst_hi_q, rx_axis_mac_tdata};
    assign dst_now_match = (dst_now == local_ip) || (BCAST_EN && (dst_now == 32'hFFFF_FFFF));
    assign dst_pass = (byte_cnt_q == 11'd19) ? dst_now_match : dst_ok_q;

    // The last header byte is always odd, so its word completes the sum here.
    assign csum_sum   = csum_q + {4'd0, csum_hi_q, rx_axis_mac_tdata};
    assign csum_fold1 = {4'd0, csum_sum[15:0]} + {16'd0, csum_sum[19:16]};
    assign csum_fold2 = csum_fold1[15:0] + {12'd0, csum_fold1[19:16]};
    assign csum_ok    = (csum_fold2 == 16'hFFFF);

    assign proto_ok = (proto_q == PROTO_ICMP) || (proto_q == PROTO_UDP);
    assign reject   = (ver_q != 4'd4) || (ihl_q < 4'd5) || !csum_ok || !dst_pass ||
                      !proto_ok || frag_bad_q || (tot_len_q <= hdr_len);

    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        ver_d       = ver_q;
        ihl_d       = ihl_q;
        tot_len_d   = tot_len_q;
        frag_bad_d  = frag_bad_q;
        proto_d     = proto_q;
        src_d       = src_q;
        dst_hi_d    = dst_hi_q;
        dst_ok_d    = dst_ok_q;
        csum_hi_d   = csum_hi_q;
        csum_d      = csum_q;
        pay_cnt_d   = pay_cnt_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_user_d  = 2'b00;
        out_dest_d  = out_dest_q;
        src_addr_d  = src_addr_q;
        drop_d      = 1'b0;

        case (state_q)
            SYNC, DROP: begin
                if (beat && rx_axis_mac_tlast) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (beat) begin
                    ver_d      = rx_axis_mac_tdata[7:4];
                    ihl_d      = rx_axis_mac_tdata[3:0];
                    csum_hi_d  = rx_axis_mac_tdata;
                    csum_d     = 20'd0;
                    frag_bad_d = 1'b0;
                    byte_cnt_d = 11'd1;
                    if (rx_axis_mac_tlast) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = HDR;
                    end
                end
            end

            HDR: begin
                if (beat) begin
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    if (byte_cnt_q[0]) begin
                        csum_d = csum_sum;
                    end else begin
                        csum_hi_d = rx_axis_mac_tdata;
                    end

                    case (byte_cnt_q)
                        11'd2:  tot_len_d[15:8] = rx_axis_mac_tdata;
                        11'd3:  tot_len_d[7:0]  = rx_axis_mac_tdata;
                        // MF is bit 5 of byte 6; DF and the reserved bit are ignored.
                        11'd6:  frag_bad_d = rx_axis_mac_tdata[5] | (|rx_axis_mac_tdata[4:0]);
                        11'd7:  frag_bad_d = frag_bad_q | (|rx_axis_mac_tdata);
                        11'd9:  proto_d = rx_axis_mac_tdata;
                        11'd12, 11'd13, 11'd14, 11'd15:
                                src_d = {src_q[23:0], rx_axis_mac_tdata};
                        11'd16, 11'd17, 11'd18:
                                dst_hi_d = {dst_hi_q[15:0], rx_axis_mac_tdata};
                        11'd19: dst_ok_d = dst_now_match;
                        default: ;
                    endcase

                    if (rx_axis_mac_tlast) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end else if (byte_cnt_q == hdr_end) begin
                        if (reject) begin
                            drop_d  = 1'b1;
                            state_d = DROP;
                        end else begin
                            out_dest_d = (proto_q == PROTO_ICMP);
                            src_addr_d = src_q;
                            pay_cnt_d  = tot_len_q - hdr_len;
                            state_d    = PAYLOAD;
                        end
                    end
                end
            end

            PAYLOAD: begin
                if (beat) begin
                    pay_cnt_d = pay_cnt_q - 16'd1;
                    if (pay_cnt_q == 16'd1) begin
                        if (rx_axis_mac_tlast) begin
                            out_valid_d = 1'b1;
                            out_data_d  = rx_axis_mac_tdata;
                            out_last_d  = 1'b1;
                            out_user_d  = {1'b0, rx_axis_mac_tuser};
                            state_d     = IDLE;
                        end else begin
                            // The real end of packet is unknown until the padding ends.
                            hold_d  = rx_axis_mac_tdata;
                            state_d = PAD;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = rx_axis_mac_tdata;
                        if (rx_axis_mac_tlast) begin
                            out_last_d = 1'b1;
                            out_user_d = {1'b1, rx_axis_mac_tuser};
                            state_d    = IDLE;
                        end
                    end
                end
            end

            PAD: begin
                if (beat && rx_axis_mac_tlast) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hold_q;
                    out_last_d  = 1'b1;
                    out_user_d  = {1'b0, rx_axis_mac_tuser};
                    state_d     = IDLE;
                end
            end

            default: state_d = SYNC;
        endcase
    end

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    // NOTE: header capture registers are reset too; reset starts in SYNC and may hit mid-frame.
    always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
        if (rx_mac_reset) begin
            state_q     <= SYNC;
            byte_cnt_q  <= '0;
            ver_q       <= '0;
            ihl_q       <= '0;
            tot_len_q   <= '0;
            frag_bad_q  <= 1'b0;
            proto_q     <= '0;
            src_q       <= '0;
            dst_hi_q    <= '0;
            dst_ok_q    <= 1'b0;
            csum_hi_q   <= '0;
            csum_q      <= '0;
            pay_cnt_q   <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            out_dest_q  <= 1'b0;
            src_addr_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            ver_q       <= ver_d;
            ihl_q       <= ihl_d;
            tot_len_q   <= tot_len_d;
            frag_bad_q  <= frag_bad_d;
            proto_q     <= proto_d;
            src_q       <= src_d;
            dst_hi_q    <= dst_hi_d;
            dst_ok_q    <= dst_ok_d;
            csum_hi_q   <= csum_hi_d;
            csum_q      <= csum_d;
            pay_cnt_q   <= pay_cnt_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            out_dest_q  <= out_dest_d;
            src_addr_q  <= src_addr_d;
            drop_q      <= drop_d;
        end
    end

    assign rx_axis_ip_tdata  = out_data_q;
    assign rx_axis_ip_tvalid = out_valid_q;
    assign rx_axis_ip_tlast  = out_last_q;
    assign rx_axis_ip_tuser  = out_user_q;
    assign rx_axis_ip_tdest  = out_dest_q;
    assign rx_ip_src_addr    = src_addr_q;
    assign rx_ip_drop        = drop_q;

endmodule

// File: tb/tb_ip_rx_parser.sv
// Self-checking bench for ip_rx_parser: a table of packet vectors with hand-computed
// expected beat counts, plus directed reset-mid-payload and back-to-back sequences.
module tb_ip_rx_parser;

    localparam logic [31:0] LIP = 32'hC0A8_010A;   // 192.168.1.10
    localparam int NV = 16;

    logic        rx_mac_aclk = 1'b0;
    logic        rx_mac_reset;
    logic [31:0] local_ip;
    logic [7:0]  rx_axis_mac_tdata;
    logic        rx_axis_mac_tvalid;
    logic        rx_axis_mac_tlast;
    logic        rx_axis_mac_tuser;
    logic [7:0]  rx_axis_ip_tdata;
    logic        rx_axis_ip_tvalid;
    logic        rx_axis_ip_tlast;
    logic [1:0]  rx_axis_ip_tuser;
    logic        rx_axis_ip_tdest;
    logic [31:0] rx_ip_src_addr;
    logic        rx_ip_drop;

    ip_rx_parser #(.BCAST_EN(1'b1)) dut (
        .rx_mac_aclk        (rx_mac_aclk),
        .rx_mac_reset       (rx_mac_reset),
        .local_ip           (local_ip),
        .rx_axis_mac_tdata  (rx_axis_mac_tdata),
        .rx_axis_mac_tvalid (rx_axis_mac_tvalid),
        .rx_axis_mac_tlast  (rx_axis_mac_tlast),
        .rx_axis_mac_tuser  (rx_axis_mac_tuser),
        .rx_axis_ip_tdata   (rx_axis_ip_tdata),
        .rx_axis_ip_tvalid  (rx_axis_ip_tvalid),
        .rx_axis_ip_tlast   (rx_axis_ip_tlast),
        .rx_axis_ip_tuser   (rx_axis_ip_tuser),
        .rx_axis_ip_tdest   (rx_axis_ip_tdest),
        .rx_ip_src_addr     (rx_ip_src_addr),
        .rx_ip_drop         (rx_ip_drop)
    );

    always #5 rx_mac_aclk = ~rx_mac_aclk;

    typedef struct {
        logic [3:0]  ver;
        logic [3:0]  ihl;
        logic [7:0]  proto;
        logic [31:0] dst;
        int          tot_len;
        int          frame_len;
        bit          mf;
        bit          bad_csum;
        bit          mac_err;
        int          gap;
        int          exp_n;
        bit          exp_dest;
        int          exp_drop;
        logic [1:0]  exp_tuser;
    } vec_t;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [1:0]  u;
        logic        dst;
        logic [31:0] src;
        int          cyc;
    } beat_t;

    vec_t       vecs [NV];
    string      names [NV];
    logic [7:0] frm [0:511];
    int         in_cyc [0:511];
    beat_t      mon_q [$];
    int         drop_cnt;
    int         cyc;
    int         n_pass;
    int         n_total;

    always @(posedge rx_mac_aclk) cyc <= cyc + 1;

    always @(negedge rx_mac_aclk) begin
        if (rx_axis_ip_tvalid) begin
            mon_q.push_back('{rx_axis_ip_tdata, rx_axis_ip_tlast, rx_axis_ip_tuser,
                              rx_axis_ip_tdest, rx_ip_src_addr, cyc});
        end
        if (rx_ip_drop) drop_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] ver, input logic [3:0] ihl,
                                input logic [7:0] proto, input logic [31:0] dst,
                                input int tot, input int frame, input bit mf,
                                input bit badc, input bit mac, input int gap,
                                input int en, input bit ed, input int edrop,
                                input logic [1:0] eu);
        vec_t v;
        v.ver = ver; v.ihl = ihl; v.proto = proto; v.dst = dst;
        v.tot_len = tot; v.frame_len = frame; v.mf = mf; v.bad_csum = badc;
        v.mac_err = mac; v.gap = gap; v.exp_n = en; v.exp_dest = ed;
        v.exp_drop = edrop; v.exp_tuser = eu;
        return v;
    endfunction

    function automatic int hlen(input vec_t v);
        return (v.ihl < 4'd5) ? 20 : 4 * int'(v.ihl);
    endfunction

    function automatic logic [15:0] hdr_csum(input int hl);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < hl; i += 2) s += {16'd0, frm[i], frm[i+1]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic build_frame(input vec_t v, input int idx);
        int hl;
        logic [15:0] cs;
        logic [31:0] src;
        hl  = hlen(v);
        src = {8'd10, 8'd0, 8'd0, 8'(idx + 1)};
        for (int i = 0; i < 512; i++) begin
            if (i < hl)             frm[i] = 8'hA0 + 8'(i);
            else if (i < v.tot_len) frm[i] = 8'(i * 13 + idx * 29 + 5);
            else                    frm[i] = 8'hEE;
        end
        frm[0]  = {v.ver, v.ihl};
        frm[1]  = 8'h00;
        frm[2]  = 8'(v.tot_len >> 8);
        frm[3]  = 8'(v.tot_len);
        frm[4]  = 8'h12;
        frm[5]  = 8'h34;
        frm[6]  = {1'b0, 1'b1, v.mf, 5'd0};
        frm[7]  = 8'h00;
        frm[8]  = 8'd64;
        frm[9]  = v.proto;
        frm[10] = 8'h00;
        frm[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            frm[12+i] = src[31-8*i -: 8];
            frm[16+i] = v.dst[31-8*i -: 8];
        end
        cs = hdr_csum(hl);
        if (v.bad_csum) cs = cs ^ 16'h0001;
        frm[10] = cs[15:8];
        frm[11] = cs[7:0];
    endtask

    task automatic send_range(input int first, input int last_i, input int len,
                              input int gap, input bit mac);
        for (int i = first; i <= last_i; i++) begin
            @(posedge rx_mac_aclk); #1;
            rx_axis_mac_tvalid = 1'b1;
            rx_axis_mac_tdata  = frm[i];
            rx_axis_mac_tlast  = (i == len - 1);
            rx_axis_mac_tuser  = (i == len - 1) && mac;
            in_cyc[i] = cyc;
            if (gap > 0 && (i % gap) == gap - 1 && i != len - 1) begin
                @(posedge rx_mac_aclk); #1;
                rx_axis_mac_tvalid = 1'b0;
                rx_axis_mac_tlast  = 1'b0;
                rx_axis_mac_tuser  = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rx_mac_aclk); #1;
            rx_axis_mac_tvalid = 1'b0;
            rx_axis_mac_tlast  = 1'b0;
            rx_axis_mac_tuser  = 1'b0;
        end
    endtask

    task automatic clear_mon();
        mon_q.delete();
        drop_cnt = 0;
    endtask

    task automatic check_packet(input int vi);
        vec_t v;
        int hl, idx, exp_cyc, bad_data, bad_time, bad_last, bad_side;
        logic [31:0] exp_src;
        v = vecs[vi];
        hl = hlen(v);
        exp_src = {8'd10, 8'd0, 8'd0, 8'(vi + 1)};
        check({names[vi], " beats"}, mon_q.size(), v.exp_n);
        check({names[vi], " drops"}, drop_cnt, v.exp_drop);
        if (v.exp_n > 0 && mon_q.size() == v.exp_n) begin
            bad_data = 0; bad_time = 0; bad_last = 0; bad_side = 0;
            for (int k = 0; k < v.exp_n; k++) begin
                idx = hl + k;
                exp_cyc = (idx == v.tot_len - 1 && v.tot_len < v.frame_len)
                          ? in_cyc[v.frame_len - 1] + 1 : in_cyc[idx] + 1;
                if (mon_q[k].d !== frm[idx]) bad_data++;
                if (mon_q[k].cyc != exp_cyc) bad_time++;
                if (mon_q[k].l !== (k == v.exp_n - 1)) bad_last++;
                if (mon_q[k].dst !== v.exp_dest || mon_q[k].src !== exp_src) bad_side++;
                if (k != v.exp_n - 1 && mon_q[k].u !== 2'b00) bad_side++;
            end
            check({names[vi], " data errors"}, bad_data, 0);
            check({names[vi], " latency errors"}, bad_time, 0);
            check({names[vi], " tlast errors"}, bad_last, 0);
            check({names[vi], " dest/src/tuser errors"}, bad_side, 0);
            check({names[vi], " final tuser"}, mon_q[v.exp_n-1].u, v.exp_tuser);
        end
    endtask

    int tl_cnt, bad_b2b;

    initial begin
        n_pass = 0; n_total = 0; cyc = 0; drop_cnt = 0;
        //                 ver  ihl proto  dst          tot frame mf bc mac gap  n  dest drop tuser
        vecs[0]  = mk(4, 5, 8'd1,  LIP,           60,  60, 0, 0, 0, 0, 40, 1, 0, 2'b00); names[0]  = "icmp_echo";
        vecs[1]  = mk(4, 5, 8'd17, LIP,           28,  46, 0, 0, 1, 0,  8, 0, 0, 2'b01); names[1]  = "udp_padded";
        vecs[2]  = mk(4, 5, 8'd1,  LIP,           40,  40, 0, 1, 0, 0,  0, 0, 1, 2'b00); names[2]  = "bad_csum";
        vecs[3]  = mk(4, 5, 8'd1,  32'hC0A8010B,  40,  40, 0, 0, 0, 0,  0, 0, 1, 2'b00); names[3]  = "bad_dst";
        vecs[4]  = mk(4, 5, 8'd6,  LIP,           40,  40, 0, 0, 0, 0,  0, 0, 1, 2'b00); names[4]  = "proto6";
        vecs[5]  = mk(4, 5, 8'd17, LIP,           40,  40, 1, 0, 0, 0,  0, 0, 1, 2'b00); names[5]  = "mf_set";
        vecs[6]  = mk(6, 5, 8'd17, LIP,           40,  40, 0, 0, 0, 0,  0, 0, 1, 2'b00); names[6]  = "version6";
        vecs[7]  = mk(4, 5, 8'd17, LIP,           40,  40, 0, 0, 0, 0, 20, 0, 0, 2'b00); names[7]  = "udp_after_rejects";
        vecs[8]  = mk(4, 5, 8'd17, LIP,          100,  50, 0, 0, 0, 0, 30, 0, 0, 2'b10); names[8]  = "truncated";
        vecs[9]  = mk(4, 6, 8'd1,  LIP,           44,  44, 0, 0, 0, 0, 20, 1, 0, 2'b00); names[9]  = "ihl6_option";
        vecs[10] = mk(4, 5, 8'd17, 32'hFFFFFFFF,  30,  30, 0, 0, 0, 0, 10, 0, 0, 2'b00); names[10] = "broadcast";
        vecs[11] = mk(4, 5, 8'd1,  LIP,           30,  30, 0, 0, 0, 3, 10, 1, 0, 2'b00); names[11] = "gappy_input";
        vecs[12] = mk(4, 5, 8'd1,  LIP,           60,  40, 0, 0, 1, 0, 20, 1, 0, 2'b11); names[12] = "trunc_mac_err";
        vecs[13] = mk(4, 5, 8'd17, LIP,           20,  46, 0, 0, 0, 0,  0, 0, 1, 2'b00); names[13] = "len_eq_hdr";
        vecs[14] = mk(4, 5, 8'd17, LIP,           21,  46, 0, 0, 0, 0,  1, 0, 0, 2'b00); names[14] = "one_byte_padded";
        vecs[15] = mk(4, 4, 8'd17, LIP,           40,  40, 0, 0, 0, 0,  0, 0, 1, 2'b00); names[15] = "ihl4";

        local_ip = LIP;
        rx_mac_reset = 1'b1;
        rx_axis_mac_tdata = 8'h00; rx_axis_mac_tvalid = 1'b0;
        rx_axis_mac_tlast = 1'b0;  rx_axis_mac_tuser = 1'b0;
        repeat (3) @(posedge rx_mac_aclk);
        @(negedge rx_mac_aclk);
        check("reset outputs", {rx_axis_ip_tdata, rx_axis_ip_tvalid, rx_axis_ip_tlast,
               rx_axis_ip_tuser, rx_axis_ip_tdest, rx_ip_drop}, 32'd0);
        check("reset src addr", rx_ip_src_addr, 32'd0);
        @(posedge rx_mac_aclk); #1;
        rx_mac_reset = 1'b0;

        // The first frame after reset is discarded by SYNC.
        build_frame(vecs[0], 0);
        clear_mon();
        send_range(0, 59, 60, 0, 1'b0);
        idle(4);
        check("sync discard beats", mon_q.size(), 0);
        check("sync discard drops", drop_cnt, 0);

        for (int i = 0; i < NV; i++) begin
            build_frame(vecs[i], i);
            clear_mon();
            send_range(0, vecs[i].frame_len - 1, vecs[i].frame_len, vecs[i].gap, vecs[i].mac_err);
            idle(4);
            check_packet(i);
        end

        // Reset in the middle of a payload, then the old frame's tail, then a good packet.
        build_frame(vecs[0], 0);
        clear_mon();
        send_range(0, 29, 60, 0, 1'b0);
        @(posedge rx_mac_aclk); #1;
        rx_axis_mac_tvalid = 1'b0;
        check("pre-reset tvalid", rx_axis_ip_tvalid, 1'b1);
        #2;
        rx_mac_reset = 1'b1;
        #1;
        check("async reset outputs", {rx_axis_ip_tdata, rx_axis_ip_tvalid, rx_axis_ip_tlast,
               rx_axis_ip_tuser, rx_axis_ip_tdest, rx_ip_drop}, 32'd0);
        check("async reset src addr", rx_ip_src_addr, 32'd0);
        @(posedge rx_mac_aclk); #1;
        @(posedge rx_mac_aclk); #1;
        rx_mac_reset = 1'b0;
        clear_mon();
        send_range(30, 59, 60, 0, 1'b0);
        idle(4);
        check("tail after reset beats", mon_q.size(), 0);
        check("tail after reset drops", drop_cnt, 0);
        build_frame(vecs[7], 7);
        clear_mon();
        send_range(0, 39, 40, 0, 1'b0);
        idle(4);
        check_packet(7);

        // Back-to-back packets with no idle cycle between them.
        clear_mon();
        build_frame(vecs[0], 0);
        send_range(0, 59, 60, 0, 1'b0);
        build_frame(vecs[7], 7);
        send_range(0, 39, 40, 0, 1'b0);
        idle(4);
        check("b2b beats", mon_q.size(), 60);
        check("b2b drops", drop_cnt, 0);
        tl_cnt = 0;
        bad_b2b = 0;
        foreach (mon_q[k]) if (mon_q[k].l) tl_cnt++;
        check("b2b tlast count", tl_cnt, 2);
        if (mon_q.size() == 60) begin
            for (int k = 0; k < 20; k++) begin
                if (mon_q[40+k].d !== frm[20+k] || mon_q[40+k].dst !== 1'b0) bad_b2b++;
            end
            check("b2b second packet errors", bad_b2b, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
